mem_vin_buffer_ctrl: RTL and testbench

MEM_VIN_BUFFER_CTRL -- requirements
Module: mem_vin_buffer_ctrl

---
 rtl/mem_vin_buffer_ctrl_if.sv | 29 ++
 rtl/mem_vin_buffer_ctrl.sv | 163 ++++++++++++++++
 tb/tb_mem_vin_buffer_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_vin_buffer_ctrl_if.sv
// mem_vin_buffer_ctrl_if: groups the scan/word input side and the DDR write-burst side of the buffer controller
// Ports (slave view): laser_start_i, fbc_data_vld_i, fbc_data_i in; wr_burst_line_o, buffer_overflow_o, wr_busy_o out;
//   wr_ddr_req_o/len_o/addr_o out, wr_ddr_data_req_i in, wr_ddr_data_o out, wr_ddr_finish_i in
interface mem_vin_buffer_ctrl_if #(
  parameter int ADDR_WIDTH    = 30,
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_DATA_BITS = 256
);
  logic                     laser_start_i;
  logic                     fbc_data_vld_i;
  logic [DATA_WIDTH-1:0]    fbc_data_i;
  logic [17:0]              wr_burst_line_o;
  logic                     buffer_overflow_o;
  logic                     wr_busy_o;
  logic                     wr_ddr_req_o;
  logic [7:0]               wr_ddr_len_o;
  logic [ADDR_WIDTH-1:0]    wr_ddr_addr_o;
  logic                     wr_ddr_data_req_i;
  logic [MEM_DATA_BITS-1:0] wr_ddr_data_o;
  logic                     wr_ddr_finish_i;
  modport slave (
    input  laser_start_i, fbc_data_vld_i, fbc_data_i, wr_ddr_data_req_i, wr_ddr_finish_i,
    output wr_burst_line_o, buffer_overflow_o, wr_busy_o, wr_ddr_req_o, wr_ddr_len_o, wr_ddr_addr_o, wr_ddr_data_o
  );
  modport master (
    output laser_start_i, fbc_data_vld_i, fbc_data_i, wr_ddr_data_req_i, wr_ddr_finish_i,
    input  wr_burst_line_o, buffer_overflow_o, wr_busy_o, wr_ddr_req_o, wr_ddr_len_o, wr_ddr_addr_o, wr_ddr_data_o
  );
endinterface

// File: rtl/mem_vin_buffer_ctrl.sv
// mem_vin_buffer_ctrl: packs scan words into DDR beats, queues them in a FWFT FIFO and issues fixed-length write bursts
// Ports: ddr_clk_i (sole clock), ddr_rst_n_i (async active-low reset), bus (mem_vin_buffer_ctrl_if.slave: scan input,
//   word strobe/data, burst request/len/addr, beat pop/data, burst finish, burst line count, overflow, busy)
module mem_vin_buffer_ctrl #(
  parameter real TCQ           = 0.1,
  parameter int  ADDR_WIDTH    = 30,
  parameter int  DATA_WIDTH    = 32,
  parameter int  MEM_DATA_BITS = 256,
  parameter int  BURST_LEN     = 128,
  parameter int  FIFO_DEPTH    = 256
) (
  input logic                  ddr_clk_i,
  input logic                  ddr_rst_n_i,
  mem_vin_buffer_ctrl_if.slave bus
);
  localparam int LANES = MEM_DATA_BITS / DATA_WIDTH;
  localparam int KW    = $clog2(LANES);
  localparam int AW    = $clog2(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, WAIT_DATA, BURSTING, BURST_END, FLUSH, FLUSH_BURST} state_t;
  state_t                   state;
  logic [2:0]               sync;
  logic                     scan, scan_rise, scan_fall, clr;
  logic [KW-1:0]            k, k_base;
  logic [MEM_DATA_BITS-1:0] pack, pack_base, pack_in, push_data;
  logic                     take, word_push, flush_push, push_req, push, drop, pop, full, empty;
  logic [AW:0]              cnt;
  logic [AW-1:0]            wp, rp;
  logic [MEM_DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic                     req, ovf, busy, fall_pend, sat;
  logic [7:0]               len;
  logic [ADDR_WIDTH-1:0]    addr;
  logic [17:0]              line;
  // sync[1] is the synchronised scan level, sync[2] the extra stage used for edge detection
  assign scan      = sync[1];
  assign scan_rise = sync[1] & ~sync[2];
  assign scan_fall = ~sync[1] & sync[2];
  assign clr       = scan_rise && state == IDLE;
  // a word arriving in the clearing cycle lands in lane 0 of a fresh packer
  assign k_base     = clr ? '0 : k;
  assign pack_base  = clr ? '0 : pack;
  assign take       = bus.fbc_data_vld_i & scan;
  assign word_push  = take && k_base == KW'(LANES - 1);
  assign flush_push = state == FLUSH && k != '0;
  assign push_req   = word_push | flush_push;
  assign push_data  = word_push ? pack_in : pack;
  assign full       = cnt[AW];
  assign empty      = cnt == '0;
  assign push       = push_req & ~full;
  assign drop       = push_req & full;
  assign pop        = bus.wr_ddr_data_req_i & ~empty;
  assign sat        = &line;
  always_comb begin
    pack_in = pack_base;
    pack_in[k_base*DATA_WIDTH +: DATA_WIDTH] = bus.fbc_data_i;
  end
  always_ff @(posedge ddr_clk_i or negedge ddr_rst_n_i)
    if (!ddr_rst_n_i) sync <= '0;
    else sync <= {sync[1:0], bus.laser_start_i};
  // lanes are cleared after every push so a flushed partial beat already has zero upper lanes
  always_ff @(posedge ddr_clk_i or negedge ddr_rst_n_i)
    if (!ddr_rst_n_i) begin
      k    <= '0;
      pack <= '0;
    end else if (flush_push) begin
      k    <= '0;
      pack <= '0;
    end else if (take) begin
      k    <= k_base + KW'(1);
      pack <= word_push ? '0 : pack_in;
    end else if (clr) begin
      k    <= '0;
      pack <= '0;
    end
  always_ff @(posedge ddr_clk_i or negedge ddr_rst_n_i)
    if (!ddr_rst_n_i) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (clr) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge ddr_clk_i)
    if (push) mem[wp] <= push_data;
  always_ff @(posedge ddr_clk_i or negedge ddr_rst_n_i)
    if (!ddr_rst_n_i) begin
      state     <= IDLE;
      req       <= 1'b0;
      len       <= '0;
      addr      <= '0;
      line      <= '0;
      ovf       <= 1'b0;
      busy      <= 1'b0;
      fall_pend <= 1'b0;
    end else begin
      if (drop) ovf <= 1'b1;
      if (req && (bus.wr_ddr_data_req_i || bus.wr_ddr_finish_i)) req <= 1'b0;
      if (scan_fall && state != IDLE) fall_pend <= 1'b1;
      case (state)
        IDLE:
          if (scan_rise) begin
            state     <= WAIT_DATA;
            busy      <= 1'b1;
            line      <= '0;
            ovf       <= 1'b0;
            fall_pend <= 1'b0;
          end
        WAIT_DATA:
          if (cnt >= (AW+1)'(BURST_LEN)) begin
            if (sat) ovf <= 1'b1;
            else begin
              state <= BURSTING;
              req   <= 1'b1;
              len   <= 8'(BURST_LEN);
              addr  <= ADDR_WIDTH'({line, 10'd0});
            end
          end else if (scan_fall || fall_pend) state <= FLUSH;
        BURSTING:
          if (bus.wr_ddr_finish_i) state <= BURST_END;
        BURST_END: begin
          line  <= sat ? line : line + 18'd1;
          state <= (fall_pend || scan_fall) ? FLUSH : WAIT_DATA;
        end
        FLUSH: begin
          fall_pend <= 1'b0;
          // a partial beat pushed this cycle is not in cnt yet, so k counts as pending data too
          if (cnt != '0 || k != '0) begin
            if (sat) begin
              ovf   <= 1'b1;
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= FLUSH_BURST;
              req   <= 1'b1;
              len   <= 8'(BURST_LEN);
              addr  <= ADDR_WIDTH'({line, 10'd0});
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        FLUSH_BURST:
          if (bus.wr_ddr_finish_i) begin
            line  <= sat ? line : line + 18'd1;
            state <= FLUSH;
          end
        default: state <= IDLE;
      endcase
    end
  assign bus.wr_ddr_req_o      = req;
  assign bus.wr_ddr_len_o      = len;
  assign bus.wr_ddr_addr_o     = addr;
  assign bus.wr_burst_line_o   = line;
  assign bus.buffer_overflow_o = ovf;
  assign bus.wr_busy_o         = busy;
  assign bus.wr_ddr_data_o     = empty ? '0 : mem[rp];
endmodule

// File: tb/tb_mem_vin_buffer_ctrl.sv
// tb_mem_vin_buffer_ctrl: directed bench for mem_vin_buffer_ctrl covering bursts, flush, overflow, reset and scan-fall handling
module tb_mem_vin_buffer_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  mem_vin_buffer_ctrl_if bus ();
  mem_vin_buffer_ctrl dut (.ddr_clk_i(clk), .ddr_rst_n_i(rst_n), .bus(bus));
  int total = 0;
  int bad = 0;
  logic [255:0] b, acc;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] mk(input int base, input int n);
    logic [255:0] r;
    r = '0;
    for (int l = 0; l < 8; l++) if (l < n) r[32*l +: 32] = 32'(base + l);
    return r;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      bus.fbc_data_vld_i = 1'b1;
      bus.fbc_data_i = 32'(base + i);
      @(negedge clk);
    end
    bus.fbc_data_vld_i = 1'b0;
  endtask

  task automatic wait_req();
    int t;
    t = 0;
    while (!bus.wr_ddr_req_o && t < 4000) begin
      @(negedge clk);
      t++;
    end
    chk("req_seen", 256'(bus.wr_ddr_req_o), 256'(1));
  endtask

  task automatic pop(output logic [255:0] v);
    v = bus.wr_ddr_data_o;
    bus.wr_ddr_data_req_i = 1'b1;
    @(negedge clk);
    bus.wr_ddr_data_req_i = 1'b0;
  endtask

  task automatic pop_n(input int n);
    logic [255:0] v;
    for (int i = 0; i < n; i++) pop(v);
  endtask

  task automatic fin();
    bus.wr_ddr_finish_i = 1'b1;
    @(negedge clk);
    bus.wr_ddr_finish_i = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req"}, 256'(bus.wr_ddr_req_o), '0);
    chk({tag, "_len"}, 256'(bus.wr_ddr_len_o), '0);
    chk({tag, "_addr"}, 256'(bus.wr_ddr_addr_o), '0);
    chk({tag, "_data"}, bus.wr_ddr_data_o, '0);
    chk({tag, "_line"}, 256'(bus.wr_burst_line_o), '0);
    chk({tag, "_ovf"}, 256'(bus.buffer_overflow_o), '0);
    chk({tag, "_busy"}, 256'(bus.wr_busy_o), '0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.laser_start_i = 1'b0;
    bus.fbc_data_vld_i = 1'b0;
    bus.fbc_data_i = '0;
    bus.wr_ddr_data_req_i = 1'b0;
    bus.wr_ddr_finish_i = 1'b0;
    cyc(3);
    chk_zero("reset");
    rst_n = 1'b1;
    cyc(2);
    // single burst from 1024 words
    bus.laser_start_i = 1'b1;
    cyc(5);
    chk("t1_busy", 256'(bus.wr_busy_o), 256'(1));
    send(0, 1024);
    wait_req();
    chk("t1_addr", 256'(bus.wr_ddr_addr_o), 256'(0));
    chk("t1_len", 256'(bus.wr_ddr_len_o), 256'(128));
    pop(b);
    chk("t1_beat0", b, mk(0, 8));
    chk("t1_req_drop", 256'(bus.wr_ddr_req_o), 256'(0));
    pop_n(126);
    pop(b);
    chk("t1_beat127", b, mk(1016, 8));
    chk("t1_line_pre", 256'(bus.wr_burst_line_o), 256'(0));
    fin();
    cyc(2);
    chk("t1_line", 256'(bus.wr_burst_line_o), 256'(1));
    bus.laser_start_i = 1'b0;
    cyc(6);
    chk("t1_idle", 256'(bus.wr_busy_o), 256'(0));
    // two bursts with delayed finish
    bus.laser_start_i = 1'b1;
    cyc(5);
    chk("t2_line_clr", 256'(bus.wr_burst_line_o), 256'(0));
    send(0, 1024);
    wait_req();
    chk("t2_addr0", 256'(bus.wr_ddr_addr_o), 256'(0));
    pop_n(128);
    cyc(200);
    chk("t2_line_hold", 256'(bus.wr_burst_line_o), 256'(0));
    fin();
    cyc(2);
    chk("t2_line1", 256'(bus.wr_burst_line_o), 256'(1));
    send(1024, 1024);
    wait_req();
    chk("t2_addr1", 256'(bus.wr_ddr_addr_o), 256'h400);
    pop(b);
    chk("t2_beat0", b, mk(1024, 8));
    pop_n(127);
    cyc(200);
    fin();
    cyc(2);
    chk("t2_line2", 256'(bus.wr_burst_line_o), 256'(2));
    chk("t2_ovf", 256'(bus.buffer_overflow_o), 256'(0));
    bus.laser_start_i = 1'b0;
    cyc(6);
    // partial scan flushed as one burst
    bus.laser_start_i = 1'b1;
    cyc(5);
    send(0, 13);
    bus.laser_start_i = 1'b0;
    wait_req();
    chk("t3_addr", 256'(bus.wr_ddr_addr_o), 256'(0));
    chk("t3_len", 256'(bus.wr_ddr_len_o), 256'(128));
    pop(b);
    chk("t3_beat0", b, mk(0, 8));
    pop(b);
    chk("t3_beat1", b, mk(8, 5));
    acc = '0;
    for (int i = 0; i < 126; i++) begin
      pop(b);
      acc |= b;
    end
    chk("t3_tail_zero", acc, '0);
    fin();
    cyc(3);
    chk("t3_line", 256'(bus.wr_burst_line_o), 256'(1));
    chk("t3_idle", 256'(bus.wr_busy_o), 256'(0));
    // overflow with the controller stalled
    bus.laser_start_i = 1'b1;
    cyc(5);
    send(0, 2048);
    chk("t4_ovf_full", 256'(bus.buffer_overflow_o), 256'(0));
    send(2048, 8);
    chk("t4_ovf", 256'(bus.buffer_overflow_o), 256'(1));
    pop(b);
    chk("t4_first", b, mk(0, 8));
    pop_n(254);
    pop(b);
    chk("t4_last", b, mk(2040, 8));
    chk("t4_empty", bus.wr_ddr_data_o, '0);
    pop(b);
    chk("t4_pop_empty", b, '0);
    send(5000, 8);
    chk("t4_after_empty", bus.wr_ddr_data_o, mk(5000, 8));
    fin();
    cyc(2);
    chk("t4_line", 256'(bus.wr_burst_line_o), 256'(1));
    // reset in the middle of a burst, then rescan
    send(0, 1016);
    wait_req();
    chk("t5_addr_pre", 256'(bus.wr_ddr_addr_o), 256'h400);
    pop_n(10);
    rst_n = 1'b0;
    bus.laser_start_i = 1'b0;
    cyc(2);
    chk_zero("t5_rst");
    rst_n = 1'b1;
    cyc(3);
    chk("t5_idle", 256'(bus.wr_busy_o), 256'(0));
    bus.laser_start_i = 1'b1;
    cyc(5);
    send(0, 1024);
    wait_req();
    chk("t5_addr", 256'(bus.wr_ddr_addr_o), 256'(0));
    pop(b);
    chk("t5_beat0", b, mk(0, 8));
    pop_n(127);
    fin();
    cyc(2);
    chk("t5_line", 256'(bus.wr_burst_line_o), 256'(1));
    bus.laser_start_i = 1'b0;
    cyc(6);
    // scan fall during a burst, words while scan low are dropped
    bus.laser_start_i = 1'b1;
    cyc(5);
    send(0, 1040);
    wait_req();
    chk("t6_addr0", 256'(bus.wr_ddr_addr_o), 256'(0));
    bus.laser_start_i = 1'b0;
    cyc(6);
    chk("t6_busy", 256'(bus.wr_busy_o), 256'(1));
    chk("t6_req_kept", 256'(bus.wr_ddr_req_o), 256'(1));
    send(9000, 8);
    pop(b);
    chk("t6_beat0", b, mk(0, 8));
    pop_n(127);
    fin();
    wait_req();
    chk("t6_addr1", 256'(bus.wr_ddr_addr_o), 256'h400);
    pop(b);
    chk("t6_fbeat0", b, mk(1024, 8));
    pop(b);
    chk("t6_fbeat1", b, mk(1032, 8));
    pop(b);
    chk("t6_fbeat2", b, '0);
    pop_n(125);
    fin();
    cyc(3);
    chk("t6_line", 256'(bus.wr_burst_line_o), 256'(2));
    chk("t6_idle", 256'(bus.wr_busy_o), 256'(0));
    chk("t6_ovf", 256'(bus.buffer_overflow_o), 256'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
